// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types and constants for the fetch stage, its parent core and its bench.
// Combinational only: no latency and no flow control.
// Holds the fetch FSM state encoding and the decode-facing fetch record.
package fetch_stage_pkg;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PC_STEP  = 64'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding bus request, 1-entry output register toward decode.
// Latency: data_ok to out_valid is 1 cycle; at most one instruction every 2 cycles.
// Backpressure: holds out_data and stops requesting until out_ready; FETCH_PERF_EN adds counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = fetch_stage_pkg::PC_RESET,
    parameter logic [63:0] PC_STEP  = fetch_stage_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out_data
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_dropped
`endif
);

    fetch_state_t state_q;
    logic [63:0]  pc_q;
    logic [63:0]  req_addr_q;
    fetch_data_t  out_buf_q;
    logic         run_q;
    logic [63:0]  pc_seq_d;

    assign pc_seq_d = req_addr_q + PC_STEP;

    // run_q keeps both valids low during reset without a path from resetn to an output.
    assign ireq_valid = run_q && (state_q != S_HOLD);
    assign ireq_addr  = req_addr_q;
    assign out_valid  = run_q && (state_q == S_HOLD);
    assign out_data   = out_buf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            out_buf_q  <= '0;
            run_q      <= 1'b0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (iresp_data_ok && !redirect_valid) begin
                        out_buf_q <= '{raw_instr: iresp_data, pc: req_addr_q};
                        pc_q      <= pc_seq_d;
                        state_q   <= S_HOLD;
                    end else if (iresp_data_ok) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                    end else if (redirect_valid) begin
                        // The bus address must stay put until the stale response returns.
                        pc_q    <= redirect_pc;
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (iresp_data_ok) begin
                        req_addr_q <= redirect_valid ? redirect_pc : pc_q;
                        state_q    <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                        state_q    <= S_FETCH;
                    end else if (out_ready) begin
                        req_addr_q <= pc_q;
                        state_q    <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched_q;
    logic [63:0] perf_dropped_q;
    logic        hs_d;
    logic        drop_d;

    assign hs_d   = out_valid && out_ready;
    assign drop_d = run_q && iresp_data_ok &&
                    (state_q == S_DROP || (state_q == S_FETCH && redirect_valid));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (hs_d) begin
                perf_fetched_q <= perf_fetched_q + 64'd1;
            end
            if (drop_d) begin
                perf_dropped_q <= perf_dropped_q + 64'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// bus latency, redirects, backpressure and resets checked each cycle against a reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    fetch_data_t out_data;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    // Reference model: next pc, address of the outstanding request, whether that request
    // is stale, and the instruction waiting for decode (if any).
    logic [63:0] m_pc;
    logic [63:0] m_req;
    logic        m_stale;
    logic        m_hold;
    logic        m_live;
    logic [95:0] m_buf;
    logic [63:0] m_fetched;
    logic [63:0] m_dropped;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pc      = PC_RESET;
        m_req     = PC_RESET;
        m_stale   = 1'b0;
        m_hold    = 1'b0;
        m_live    = 1'b0;
        m_buf     = '0;
        m_fetched = '0;
        m_dropped = '0;
    endfunction

    function automatic void m_step();
        if (!m_live) begin
            m_live = 1'b1;
        end else if (m_hold) begin
            if (out_ready) m_fetched = m_fetched + 64'd1;
            if (redirect_valid || out_ready) begin
                m_hold = 1'b0;
                if (redirect_valid) m_pc = redirect_pc;
                m_req = m_pc;
            end
        end else begin
            if (redirect_valid) m_pc = redirect_pc;
            if (iresp_data_ok) begin
                if (m_stale || redirect_valid) begin
                    m_dropped = m_dropped + 64'd1;
                    m_stale   = 1'b0;
                    m_req     = m_pc;
                end else begin
                    m_buf  = {iresp_data, m_req};
                    m_pc   = m_req + PC_STEP;
                    m_hold = 1'b1;
                end
            end else if (redirect_valid) begin
                m_stale = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ireq_valid", {95'd0, ireq_valid}, {95'd0, m_live && !m_hold});
            check("ireq_addr", {32'd0, ireq_addr}, {32'd0, m_req});
            check("out_valid", {95'd0, out_valid}, {95'd0, m_hold});
            check("out_data", out_data, m_buf);
`ifdef FETCH_PERF_EN
            check("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
            check("perf_dropped", {32'd0, perf_dropped}, {32'd0, m_dropped});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        if (resetn) m_step();
        #1;
    endtask

    function automatic logic [63:0] pick_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
        if (sel == 1) return {$urandom, $urandom};
        return PC_RESET + 64'($urandom_range(0, 1023) * 4);
    endfunction

    bit act;
    int wl;

    initial begin
        m_reset();
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst ireq_valid", {95'd0, ireq_valid}, 96'd0);
        check("rst out_valid", {95'd0, out_valid}, 96'd0);
        check("rst out_data", out_data, 96'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        step();
        check("first req valid", {95'd0, ireq_valid}, 96'd1);
        check("first req addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0000});

        iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093; out_ready = 1'b1;
        step();
        check("instr0 valid", {95'd0, out_valid}, 96'd1);
        check("instr0 data", out_data, {32'h0010_0093, 64'h8000_0000});
        check("hold no req", {95'd0, ireq_valid}, 96'd0);
        iresp_data_ok = 1'b0;
        step();
        check("second req addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0004});
        check("gap out_valid", {95'd0, out_valid}, 96'd0);
        iresp_data_ok = 1'b1; iresp_data = 32'h0020_0113;
        step();
        check("instr1 data", out_data, {32'h0020_0113, 64'h8000_0004});
        iresp_data_ok = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp out_valid", {95'd0, out_valid}, 96'd1);
            check("bp out_data", out_data, {32'h0020_0113, 64'h8000_0004});
            check("bp ireq_valid", {95'd0, ireq_valid}, 96'd0);
        end
        out_ready = 1'b1;
        step();
        check("after bp addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0008});
        out_ready = 1'b0;

        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stale addr held", {32'd0, ireq_addr}, {32'd0, 64'h8000_0008});
            step();
        end
        check("stale addr held", {32'd0, ireq_addr}, {32'd0, 64'h8000_0008});
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        step();
        iresp_data_ok = 1'b0;
        check("stale dropped", {95'd0, out_valid}, 96'd0);
        check("redirect addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0100});

        iresp_data_ok = 1'b1; iresp_data = 32'hCAFE_F00D;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        check("same-cycle drop", {95'd0, out_valid}, 96'd0);
        check("same-cycle addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0200});
        iresp_data = 32'h0030_0193;
        step();
        iresp_data_ok = 1'b0;
        check("hold at 200", out_data, {32'h0030_0193, 64'h8000_0200});
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        step();
        redirect_valid = 1'b0;
        check("hold redirect valid", {95'd0, out_valid}, 96'd0);
        check("hold redirect addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0300});
`ifdef FETCH_PERF_EN
        check("perf fetched lit", {32'd0, perf_fetched}, {32'd0, 64'd2});
        check("perf dropped lit", {32'd0, perf_dropped}, {32'd0, 64'd2});
`endif
        step();

        #1 resetn = 1'b0;
        m_reset();
        #1;
        check("async ireq_valid", {95'd0, ireq_valid}, 96'd0);
        check("async out_valid", {95'd0, out_valid}, 96'd0);
`ifdef FETCH_PERF_EN
        check("async perf fetched", {32'd0, perf_fetched}, 96'd0);
        check("async perf dropped", {32'd0, perf_dropped}, 96'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        step();
        check("post-reset addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0000});
        check("post-reset valid", {95'd0, ireq_valid}, 96'd1);

        act = 1'b0;
        wl  = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 701 == 700) begin
                resetn = 1'b0;
                m_reset();
                act = 1'b0;
                iresp_data_ok = 1'b0;
                redirect_valid = 1'b0;
                step();
                step();
                resetn = 1'b1;
            end
            if (!ireq_valid) begin
                act = 1'b0;
                iresp_data_ok = 1'b0;
            end else begin
                if (!act) begin
                    act = 1'b1;
                    wl  = $urandom_range(0, 3);
                end
                if (wl == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = $urandom;
                    act           = 1'b0;
                end else begin
                    wl--;
                    iresp_data_ok = 1'b0;
                end
            end
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_pc    = pick_target();
            out_ready      = ($urandom_range(0, 2) != 0);
            step();
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
